// File: rtl/md_unit_p.sv
// md_unit_p: multi-cycle multiply/divide unit for the E stage. Owns HI/LO.
//
// Parameters:
//   WIDTH        operand and HI/LO width
//   MULT_CYCLES  busy cycles for MULT/MULTU/MADD/MADDU
//   DIV_CYCLES   busy cycles for DIV/DIVU
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   start  launch op (E-stage instruction is an md op)
//   op     000 MULT,001 MULTU,010 DIV,011 DIVU,100 MADD,101 MADDU,110 MTHI,111 MTLO
//   a, b   forwarded rs / rt operands
//   flush  exception/interrupt flush; cancels any op in flight
//   busy   op in flight (registered)
//   done   one-cycle pulse after HI/LO are written by a multi-cycle op
//   hi, lo HI/LO registers
module md_unit_p #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           stateQ, stateD;
  logic [CntW-1:0]  cntQ, cntD;
  logic [WIDTH-1:0] aQ, aD, bQ, bD;
  logic [2:0]       opQ, opD;
  logic [WIDTH-1:0] hiQ, hiD, loQ, loD;
  logic             doneQ, doneD;

  // Result is computed combinationally from the latched operands and only
  // committed at the end of the run, so the visible latency is purely cnt.
  logic                 isSigned;
  logic [2*WIDTH-1:0]   prodS, prodU, prod, acc;
  logic [WIDTH-1:0]     aAbs, bAbs, bDiv, qU, rU, quot, rem;

  always_comb begin
    isSigned = ~opQ[0];
    prodS    = {{WIDTH{aQ[WIDTH-1]}}, aQ} * {{WIDTH{bQ[WIDTH-1]}}, bQ};
    prodU    = {{WIDTH{1'b0}}, aQ} * {{WIDTH{1'b0}}, bQ};
    prod     = isSigned ? prodS : prodU;
    acc      = {hiQ, loQ} + prod;

    // Signed divide via magnitudes; MIN_NEG / -1 wraps back to MIN_NEG, rem 0.
    aAbs = (isSigned && aQ[WIDTH-1]) ? -aQ : aQ;
    bAbs = (isSigned && bQ[WIDTH-1]) ? -bQ : bQ;
    bDiv = (bAbs == '0) ? WIDTH'(1) : bAbs;  // result unused when b == 0
    qU   = aAbs / bDiv;
    rU   = aAbs % bDiv;
    quot = (isSigned && (aQ[WIDTH-1] ^ bQ[WIDTH-1])) ? -qU : qU;
    rem  = (isSigned && aQ[WIDTH-1]) ? -rU : rU;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= StIdle;
      cntQ   <= '0;
      aQ     <= '0;
      bQ     <= '0;
      opQ    <= '0;
      hiQ    <= '0;
      loQ    <= '0;
      doneQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      aQ     <= aD;
      bQ     <= bD;
      opQ    <= opD;
      hiQ    <= hiD;
      loQ    <= loD;
      doneQ  <= doneD;
    end
  end

  // Next-state logic.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    aD     = aQ;
    bD     = bQ;
    opD    = opQ;
    hiD    = hiQ;
    loD    = loQ;
    doneD  = 1'b0;

    unique case (stateQ)
      StIdle: begin
        if (start && !flush) begin
          if (op == 3'b110) begin
            hiD = a;
          end else if (op == 3'b111) begin
            loD = a;
          end else begin
            aD     = a;
            bD     = b;
            opD    = op;
            cntD   = (op[2:1] == 2'b01) ? CntW'(DIV_CYCLES - 1) : CntW'(MULT_CYCLES - 1);
            stateD = StRun;
          end
        end
      end
      StRun: begin
        if (flush) begin
          stateD = StIdle;
          cntD   = '0;
        end else if (cntQ == '0) begin
          stateD = StIdle;
          doneD  = 1'b1;
          case (opQ)
            3'b000, 3'b001: {hiD, loD} = prod;
            3'b100, 3'b101: {hiD, loD} = acc;
            3'b010, 3'b011: begin
              if (bQ != '0) begin
                hiD = rem;
                loD = quot;
              end
            end
            default: ;
          endcase
        end else begin
          cntD = cntQ - 1'b1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    busy = (stateQ == StRun);
    done = doneQ;
    hi   = hiQ;
    lo   = loQ;
  end

endmodule

// File: tb/tb_md_unit_p.sv
module tb_md_unit_p;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int numTests  = 0;
  int numFailed = 0;

  // Reference HI/LO.
  logic [31:0] mHi, mLo;

  md_unit_p #(
    .WIDTH      (32),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .flush(flush),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    numTests++;
    if (got !== exp) begin
      numFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural effect of a completed op on HI/LO.
  task automatic modelOp(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     hl, t;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = 64'(av);
    ub = 64'(bv);
    hl = {mHi, mLo};
    case (o)
      3'd0: begin t = sa * sb; {mHi, mLo} = t; end
      3'd1: begin t = ua * ub; {mHi, mLo} = t; end
      3'd4: begin t = hl + 64'(sa * sb); {mHi, mLo} = t; end
      3'd5: begin t = hl + ua * ub; {mHi, mLo} = t; end
      3'd2: if (bv != 0) begin
        q = sa / sb;
        r = sa % sb;
        t = q; mLo = t[31:0];
        t = r; mHi = t[31:0];
      end
      3'd3: if (bv != 0) begin
        t = ua / ub; mLo = t[31:0];
        t = ua % ub; mHi = t[31:0];
      end
      default: ;
    endcase
  endtask

  // Launch a multi-cycle op; flushAt>0 asserts flush in that busy cycle.
  task automatic runOp(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input int flushAt, input bit extraStart, input string tag);
    int n, busyCnt, cycles;
    n = (o[2:1] == 2'b01) ? 10 : 5;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv; flush = 1'b0;
    @(negedge clk);
    start = 1'b0;
    busyCnt = 0;
    cycles  = 0;
    while (busy && cycles < 60) begin
      busyCnt++;
      checkVal({tag, "/done_while_busy"}, 64'(done), 64'd0);
      flush = (busyCnt == flushAt);
      if (extraStart) begin
        start = 1'b1;
        op    = 3'($urandom_range(0, 7));
        a     = $urandom();
        b     = $urandom();
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    flush = 1'b0;
    checkVal({tag, "/busy_cycles"}, 64'(busyCnt), 64'((flushAt > 0) ? flushAt : n));
    checkVal({tag, "/done"}, 64'(done), (flushAt > 0) ? 64'd0 : 64'd1);
    if (flushAt == 0) modelOp(o, av, bv);
    checkVal({tag, "/hi"}, 64'(hi), 64'(mHi));
    checkVal({tag, "/lo"}, 64'(lo), 64'(mLo));
    @(negedge clk);
    checkVal({tag, "/done_pulse"}, 64'(done), 64'd0);
  endtask

  // MTHI/MTLO (or any op with flush held) in IDLE.
  task automatic moveOp(input logic [2:0] o, input logic [31:0] av, input bit withFlush,
                        input string tag);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = $urandom(); flush = withFlush;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    if (!withFlush) begin
      if (o == 3'b110) mHi = av;
      else if (o == 3'b111) mLo = av;
    end
    checkVal({tag, "/busy"}, 64'(busy), 64'd0);
    checkVal({tag, "/done"}, 64'(done), 64'd0);
    checkVal({tag, "/hi"}, 64'(hi), 64'(mHi));
    checkVal({tag, "/lo"}, 64'(lo), 64'(mLo));
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [2:0] ro;
    int         n;
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    mHi = '0; mLo = '0;
    #1;
    checkVal("reset/busy", 64'(busy), 64'd0);
    checkVal("reset/done", 64'(done), 64'd0);
    checkVal("reset/hi", 64'(hi), 64'd0);
    checkVal("reset/lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    runOp(3'b000, 32'hFFFF_FFFD, 32'd7, 0, 1'b0, "mult");
    checkVal("mult/hi_const", 64'(hi), 64'hFFFF_FFFF);
    checkVal("mult/lo_const", 64'(lo), 64'hFFFF_FFEB);

    runOp(3'b001, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, "multu");
    checkVal("multu/hi_const", 64'(hi), 64'h1);
    checkVal("multu/lo_const", 64'(lo), 64'hFFFF_FFFE);

    moveOp(3'b110, 32'h0, 1'b0, "mthi0");
    moveOp(3'b111, 32'h5, 1'b0, "mtlo5");
    runOp(3'b100, 32'hFFFF_FFFF, 32'd6, 0, 1'b0, "madd");
    checkVal("madd/hi_const", 64'(hi), 64'hFFFF_FFFF);
    checkVal("madd/lo_const", 64'(lo), 64'hFFFF_FFFF);

    runOp(3'b010, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, "div");
    checkVal("div/lo_const", 64'(lo), 64'hFFFF_FFFD);
    checkVal("div/hi_const", 64'(hi), 64'hFFFF_FFFF);

    runOp(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, "div_ovf");
    checkVal("div_ovf/lo_const", 64'(lo), 64'h8000_0000);
    checkVal("div_ovf/hi_const", 64'(hi), 64'h0);

    runOp(3'b011, 32'd1234, 32'd0, 0, 1'b0, "divu_by0");
    moveOp(3'b111, 32'h1234, 1'b0, "mtlo");
    checkVal("mtlo/lo_const", 64'(lo), 64'h1234);

    runOp(3'b001, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1'b1, "start_in_run");
    runOp(3'b000, 32'h0000_1000, 32'h0000_2000, 3, 1'b0, "flush_c3");
    runOp(3'b000, 32'h0000_1000, 32'h0000_2000, 5, 1'b0, "flush_last_mult");
    runOp(3'b011, 32'h0000_1000, 32'h0000_0007, 10, 1'b0, "flush_last_div");
    moveOp(3'b110, 32'hCAFE_F00D, 1'b1, "flush_idle_mthi");
    moveOp(3'b000, 32'h1111_1111, 1'b1, "flush_idle_mult");

    // Asynchronous reset in the middle of a DIV.
    @(negedge clk);
    start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkVal("rst_mid/busy", 64'(busy), 64'd0);
    checkVal("rst_mid/done", 64'(done), 64'd0);
    checkVal("rst_mid/hi", 64'(hi), 64'd0);
    checkVal("rst_mid/lo", 64'(lo), 64'd0);
    mHi = '0; mLo = '0;
    @(negedge clk);
    reset = 1'b1;
    runOp(3'b001, 32'd9, 32'd11, 0, 1'b0, "after_rst");

    // Randomized mix.
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      if (ro >= 3'd6) begin
        moveOp(ro, pickOperand(), ($urandom_range(0, 4) == 0), $sformatf("rnd%0d", i));
      end else begin
        n = (ro[2:1] == 2'b01) ? 10 : 5;
        runOp(ro, pickOperand(), pickOperand(),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : 0,
              1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", numTests, numFailed);
    $finish;
  end

endmodule
